// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX frame arbiter.
// Optional statistics counters are enabled with ETH_TX_ARB_STATS_EN.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PASS  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    localparam int STAT_WIDTH = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_arb_picker.sv
// Combinational channel picker: round-robin starting after last_grant_i,
// or fixed priority with the lowest requesting index winning.
module eth_tx_arb_picker
    import eth_tx_arb_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int ROUND_ROBIN = 1,
    localparam int IW         = idx_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IW-1:0]       last_grant_i,
    output logic [IW-1:0]       grant_o,
    output logic                grant_valid_o
);

    int idx;

    // Scan from the lowest-precedence candidate upward so the final hit wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (ROUND_ROBIN != 0) begin
                idx = (int'(last_grant_i) + 1 + k) % CHANNELS;
            end else begin
                idx = k;
            end
            if (req_i[idx]) begin
                grant_o       = IW'(idx);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic N:1 AXI-Stream arbiter feeding the MAC TX stream, with oversize truncation.
// Defining ETH_TX_ARB_STATS_EN adds per-channel frame and truncation counters.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int ROUND_ROBIN   = 1,
    localparam int IW           = idx_w(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    output logic [CHANNELS-1:0]            s_axis_tready,
    input  logic [CHANNELS-1:0]            s_axis_tlast,
    input  logic [CHANNELS-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic [IW-1:0]                  m_axis_tid,
    output logic                           busy
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [CHANNELS*STAT_WIDTH-1:0] stat_frames,
    output logic [CHANNELS*STAT_WIDTH-1:0] stat_trunc
`endif
);

    localparam int CW = $clog2(MAX_FRAME_LEN + 1);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  m_user_q, m_user_d;
    logic [IW-1:0]         m_tid_q, m_tid_d;

    logic [IW-1:0]         pick;
    logic                  pick_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_valid, sel_last, sel_user;
    logic                  out_ready, at_max, accept, grant_ready;

    eth_tx_arb_picker #(
        .CHANNELS   (CHANNELS),
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_picker (
        .req_i        (s_axis_tvalid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .grant_valid_o(pick_valid)
    );

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q == IW'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    assign out_ready = !m_valid_q || m_axis_tready;
    assign at_max    = (cnt_q == CW'(MAX_FRAME_LEN - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_valid_d    = m_valid_q && !m_axis_tready;
        m_last_d     = m_last_q;
        m_user_d     = m_user_q;
        m_tid_d      = m_tid_q;
        accept       = 1'b0;
        grant_ready  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ARB_PASS;
                end
            end
            ARB_PASS: begin
                grant_ready = out_ready;
                accept      = sel_valid && out_ready;
                if (accept) begin
                    m_data_d  = sel_data;
                    m_keep_d  = sel_keep;
                    m_valid_d = 1'b1;
                    m_tid_d   = grant_q;
                    m_last_d  = sel_last || at_max;
                    m_user_d  = sel_user || (at_max && !sel_last);
                    cnt_d     = (cnt_q == CW'(MAX_FRAME_LEN)) ? cnt_q : cnt_q + 1'b1;
                    if (sel_last) begin
                        state_d      = ARB_IDLE;
                        last_grant_d = grant_q;
                        cnt_d        = '0;
                    end else if (at_max) begin
                        state_d = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                // Remainder of an oversize frame is swallowed up to its tlast.
                grant_ready = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_q;
                    cnt_d        = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        for (int i = 0; i < CHANNELS; i++) begin
            s_axis_tready[i] = grant_ready && (grant_q == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(CHANNELS - 1);
            cnt_q        <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
            m_tid_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
            m_tid_q      <= m_tid_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tid    = m_tid_q;
    assign busy          = (state_q != ARB_IDLE);

`ifdef ETH_TX_ARB_STATS_EN
    logic                  frame_evt, trunc_evt;
    logic [STAT_WIDTH-1:0] frames_q [CHANNELS];
    logic [STAT_WIDTH-1:0] trunc_q  [CHANNELS];

    // A truncated frame is counted once, when its drained tail ends.
    assign frame_evt = (state_q == ARB_PASS  && accept && sel_last) ||
                       (state_q == ARB_DRAIN && sel_valid && sel_last);
    assign trunc_evt = (state_q == ARB_PASS) && accept && !sel_last && at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                frames_q[i] <= '0;
                trunc_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (grant_q == IW'(i)) begin
                    if (frame_evt) frames_q[i] <= frames_q[i] + 1'b1;
                    if (trunc_evt) trunc_q[i]  <= trunc_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_stat
        assign stat_frames[g*STAT_WIDTH +: STAT_WIDTH] = frames_q[g];
        assign stat_trunc[g*STAT_WIDTH +: STAT_WIDTH]  = trunc_q[g];
    end
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter: frame-level scoreboard plus directed literal checks.
// Stats checks are compiled in when ETH_TX_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_eth_tx_frame_arbiter;

    localparam int CH   = 2;
    localparam int DW   = 8;
    localparam int MAXF = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       last;
        logic       user;
        logic       tid;
    } obeat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic obeat_t mk(input logic [7:0] d, input logic l, input logic u, input logic t);
        obeat_t o;
        o.data = d; o.keep = 1'b1; o.last = l; o.user = u; o.tid = t;
        return o;
    endfunction

    // ---------------- main DUT (round-robin) ----------------
    logic [CH*DW-1:0] s_tdata;
    logic [CH-1:0]    s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]       m_tdata;
    logic             m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser, m_tid, busy;
`ifdef ETH_TX_ARB_STATS_EN
    logic [CH*32-1:0] stat_frames, stat_trunc, f_stat_frames, f_stat_trunc;
`endif

    eth_tx_frame_arbiter #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXF), .ROUND_ROBIN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_tid(m_tid), .busy(busy)
`ifdef ETH_TX_ARB_STATS_EN
        , .stat_frames(stat_frames), .stat_trunc(stat_trunc)
`endif
    );

    // ---------------- fixed-priority DUT ----------------
    logic [CH*DW-1:0] f_tdata;
    logic [CH-1:0]    f_tkeep, f_tvalid, f_tready, f_tlast, f_tuser;
    logic [7:0]       f_mdata;
    logic             f_mkeep, f_mvalid, f_mlast, f_muser, f_mtid, f_busy;
    logic [CH-1:0]    f_bcnt = '0;
    logic [CH-1:0]    f_acc  = '0;
    int               f_frames = 0;
    int               f_ch1    = 0;

    eth_tx_frame_arbiter #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXF), .ROUND_ROBIN(0)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(f_tdata), .s_axis_tkeep(f_tkeep), .s_axis_tvalid(f_tvalid),
        .s_axis_tready(f_tready), .s_axis_tlast(f_tlast), .s_axis_tuser(f_tuser),
        .m_axis_tdata(f_mdata), .m_axis_tkeep(f_mkeep), .m_axis_tvalid(f_mvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(f_mlast), .m_axis_tuser(f_muser),
        .m_axis_tid(f_mtid), .busy(f_busy)
`ifdef ETH_TX_ARB_STATS_EN
        , .stat_frames(f_stat_frames), .stat_trunc(f_stat_trunc)
`endif
    );

    // Both sources always valid with 2-beat frames.
    for (genvar g = 0; g < CH; g++) begin : g_fsrc
        assign f_tdata[g*DW +: DW] = {4'(g), 3'b000, f_bcnt[g]};
        assign f_tkeep[g]  = 1'b1;
        assign f_tvalid[g] = rst_n;
        assign f_tlast[g]  = f_bcnt[g];
        assign f_tuser[g]  = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) f_bcnt = '0;
        else        f_bcnt = f_bcnt ^ f_acc;
    end

    // ---------------- source driver for main DUT ----------------
    beat_t         src_q [CH][$];
    beat_t         hd    [CH];
    logic [CH-1:0] hd_v  = '0;
    logic [CH-1:0] ch_en = '1;
    logic [CH-1:0] acc_s = '0;
    logic          flush = 1'b0;

    for (genvar g = 0; g < CH; g++) begin : g_src
        assign s_tdata[g*DW +: DW] = hd[g].data;
        assign s_tkeep[g]  = hd[g].keep;
        assign s_tlast[g]  = hd[g].last;
        assign s_tuser[g]  = hd[g].user;
        assign s_tvalid[g] = hd_v[g] & ch_en[g];
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < CH; i++) begin
            if (flush) begin
                hd_v[i] = 1'b0;
                src_q[i].delete();
            end else begin
                if (acc_s[i]) hd_v[i] = 1'b0;
                if (!hd_v[i] && src_q[i].size() > 0) begin
                    hd[i]   = src_q[i].pop_front();
                    hd_v[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- reference model and compare ----------------
    obeat_t exp_q[$];
    obeat_t out_log[$];
    obeat_t mon_got, mon_e;
    int     md_cnt = 0;
    logic   md_drop = 1'b0;
    logic   md_inframe = 1'b0;
    logic   md_ch = 1'b0;
    int     md_frames [CH];
    int     md_trunc  [CH];

    // Model of a frame as the spec describes it: count beats, cut at MAXF, drop the tail.
    task automatic model_accept(input int c, input beat_t b);
        if (md_inframe) chk("no_interleave", 64'(c), 64'(md_ch));
        md_inframe = 1'b1;
        md_ch      = c[0];
        if (md_drop) begin
            if (b.last) begin
                md_drop    = 1'b0;
                md_inframe = 1'b0;
                md_frames[c]++;
            end
        end else begin
            md_cnt++;
            if (b.last) begin
                exp_q.push_back(mk(b.data, 1'b1, b.user, c[0]));
                md_cnt     = 0;
                md_inframe = 1'b0;
                md_frames[c]++;
            end else if (md_cnt == MAXF) begin
                exp_q.push_back(mk(b.data, 1'b1, 1'b1, c[0]));
                md_drop = 1'b1;
                md_trunc[c]++;
            end else begin
                exp_q.push_back(mk(b.data, 1'b0, b.user, c[0]));
            end
        end
    endtask

    always @(negedge clk) begin
        acc_s = s_tvalid & s_tready;
        f_acc = f_tvalid & f_tready;
        if (!rst_n) begin
            exp_q.delete();
            md_cnt = 0; md_drop = 1'b0; md_inframe = 1'b0;
            for (int i = 0; i < CH; i++) begin
                md_frames[i] = 0;
                md_trunc[i]  = 0;
            end
            acc_s = '0;
            f_acc = '0;
        end else begin
            if (m_tvalid && m_tready) begin
                mon_got = {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid};
                out_log.push_back(mon_got);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(mon_got), 64'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_beat", 64'(mon_got), 64'(mon_e));
                end
            end
            if (s_tready != '0) chk("tready_onehot", 64'($countones(s_tready)), 64'd1);
            if (!busy) chk("tready_idle", 64'(s_tready), 64'd0);
            if (busy && !md_drop) chk("tready_pass", 64'(|s_tready), 64'(!m_tvalid || m_tready));
            for (int i = 0; i < CH; i++) begin
                if (acc_s[i]) model_accept(i, hd[i]);
            end
            if (f_mvalid) begin
                chk("fp_tid", 64'(f_mtid), 64'd0);
                if (f_mlast) f_frames++;
            end
            if (f_tready[1]) f_ch1++;
        end
    end

    // ---------------- directed sequence ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_frame(input int c, input int n, input int base, input logic bad);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = 8'(base + k);
            b.keep = 1'b1;
            b.last = (k == n - 1);
            b.user = (k == n - 1) && bad;
            src_q[c].push_back(b);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (t < 300 && !(src_q[0].size() == 0 && src_q[1].size() == 0 && hd_v == '0 &&
                            exp_q.size() == 0 && !busy && !m_tvalid)) begin
            step(1);
            t++;
        end
        chk(nm, {60'd0, t >= 300, busy, m_tvalid, exp_q.size() != 0}, 64'd0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk(nm, {m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser, m_tid, busy, s_tready}, 64'd0);
    endtask

    initial begin
        int t;
        int n0, n1, nbad;
        logic [3:0] sq;
        m_tready = 1'b1;
        for (int i = 0; i < CH; i++) hd[i] = '0;

        step(3);
        chk_outputs_zero("reset_state");
        rst_n = 1'b1;
        step(2);

        // T1: single 4-beat frame on ch0, latency 2 clocks
        out_log.delete();
        push_frame(0, 4, 'h10, 1'b0);
        t = 0;
        while (!s_tvalid[0] && t < 20) begin step(1); t++; end
        t = 0;
        while (!m_tvalid && t < 20) begin step(1); t++; end
        chk("t1_latency", 64'(t), 64'd2);
        wait_idle("t1_idle");
        chk("t1_len", 64'(out_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            chk("t1_beat", 64'(out_log[k]), 64'(mk(8'(16 + k), k == 3, 1'b0, 1'b0)));

        // T2: both channels busy; last grant was ch0 so ch1 goes first
        out_log.delete();
        push_frame(0, 2, 'h20, 1'b0);
        push_frame(0, 2, 'h22, 1'b0);
        push_frame(1, 2, 'h30, 1'b0);
        push_frame(1, 2, 'h32, 1'b0);
        wait_idle("t2_idle");
        sq = '0;
        t  = 0;
        for (int k = 0; k < out_log.size(); k++) begin
            if (out_log[k].last && t < 4) begin
                sq[3-t] = out_log[k].tid;
                t++;
            end
        end
        chk("t2_rr_order", 64'(sq), 64'b1010);
        chk("t2_len", 64'(out_log.size()), 64'd8);

        // T3: 12-beat frame on ch1 truncated at 8
        out_log.delete();
        push_frame(1, 12, 'h40, 1'b0);
        wait_idle("t3_idle");
        chk("t3_len", 64'(out_log.size()), 64'd8);
        if (out_log.size() >= 8) begin
            chk("t3_beat7", 64'(out_log[6]), 64'(mk(8'h46, 1'b0, 1'b0, 1'b1)));
            chk("t3_beat8", 64'(out_log[7]), 64'(mk(8'h47, 1'b1, 1'b1, 1'b1)));
        end

        // T4: output backpressure 1,0,0,1 during a 6-beat frame
        out_log.delete();
        push_frame(0, 6, 'h50, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1);
            m_tready = (k % 4 == 0) || (k % 4 == 3);
        end
        m_tready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_len", 64'(out_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++)
            chk("t4_data", 64'(out_log[k].data), 64'('h50 + k));

        // T5: reset after beat 2 of a 5-beat frame, then ch1 frame
        out_log.delete();
        push_frame(0, 5, 'h60, 1'b0);
        t = 0;
        while (out_log.size() < 2 && t < 50) begin step(1); t++; end
        chk("t5_reach_beat2", 64'(out_log.size()), 64'd2);
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        chk_outputs_zero("t5_reset_async");
        step(1);
        rst_n = 1'b1;
        flush = 1'b0;
        step(1);
        out_log.delete();
        push_frame(1, 3, 'h70, 1'b1);
        wait_idle("t5_idle");
        chk("t5_len", 64'(out_log.size()), 64'd3);
        if (out_log.size() >= 3) begin
            chk("t5_first", 64'(out_log[0]), 64'(mk(8'h70, 1'b0, 1'b0, 1'b1)));
            chk("t5_last", 64'(out_log[2]), 64'(mk(8'h72, 1'b1, 1'b1, 1'b1)));
        end

        // T6: fresh reset, 3 frames on ch0 and one oversize frame on ch1
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        out_log.delete();
        push_frame(0, 3, 'h80, 1'b0);
        push_frame(0, 3, 'h84, 1'b0);
        push_frame(0, 3, 'h88, 1'b0);
        push_frame(1, 10, 'h90, 1'b0);
        wait_idle("t6_idle");
        n0 = 0; n1 = 0; nbad = 0;
        for (int k = 0; k < out_log.size(); k++) begin
            if (out_log[k].last && out_log[k].tid == 1'b0) n0++;
            if (out_log[k].last && out_log[k].tid == 1'b1) n1++;
            if (out_log[k].user) nbad++;
        end
        chk("t6_frames", {32'(n1), 32'(n0)}, {32'd1, 32'd3});
        chk("t6_bad", 64'(nbad), 64'd1);
        chk("t6_len", 64'(out_log.size()), 64'd17);
`ifdef ETH_TX_ARB_STATS_EN
        chk("stat_frames", 64'(stat_frames), {32'd1, 32'd3});
        chk("stat_trunc", 64'(stat_trunc), {32'd1, 32'd0});
        chk("stat_frames_model", 64'(stat_frames), {32'(md_frames[1]), 32'(md_frames[0])});
        chk("stat_trunc_model", 64'(stat_trunc), {32'(md_trunc[1]), 32'(md_trunc[0])});
`endif

        chk("fp_ch1_never_ready", 64'(f_ch1), 64'd0);
        chk("fp_progress", 64'(f_frames > 10), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
